// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MDU_EARLY_OUT_EN to let zero-operand mult and divide-by-zero bypass the iteration phase.
module mul_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic             is_div, neg_q, neg_r, dz;

    logic             is_md, is_sgn, req_div, a_neg, b_neg, skip;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_md   = ~op[2];
        is_sgn  = ~op[0];
        req_div = op[1];
        a_neg   = is_sgn & srca[WIDTH-1];
        b_neg   = is_sgn & srcb[WIDTH-1];
        mag_a   = a_neg ? -srca : srca;
        mag_b   = b_neg ? -srcb : srcb;
        skip    = EARLY_OUT && (req_div ? (srcb == '0) : (srca == '0 || srcb == '0));
    end

    // One iteration: mult shifts the accumulator right after a conditional add,
    // div shifts left and subtracts when the partial remainder covers the divisor.
    logic [WIDTH:0]   sum, shifted;
    logic             ge;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opb};
        if (is_div) begin
            nxt_hi = ge ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_fix    = dz ? '1 : (neg_q ? -acc_lo : acc_lo);
        // divide-by-zero leaves the dividend magnitude here, so this restores raw srca
        r_fix    = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_md) begin
                        opb    <= req_div ? mag_b : mag_a;
                        acc_lo <= skip ? '0 : (req_div ? mag_a : mag_b);
                        acc_hi <= (skip && req_div) ? mag_a : '0;
                        is_div <= req_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= req_div & (srcb == '0);
                        busy   <= 1'b1;
                        cnt    <= skip ? '0 : CNT_W'(WIDTH);
                        state  <= skip ? FIX : CALC;
                    end else if (start && !op[1]) begin
                        if (op[0]) lo <= srca;
                        else       hi <= srca;
                        done <= 1'b1;
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, done/busy shape and HI/LO results per op.
// Cycle c is the c-th negedge after the edge that accepts start.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] srca = '0, srcb = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch until two cycles past done (or 60 cycles).
    // inj>0 pulses a DIV start at that cycle, which must be ignored while busy.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input int exp_busy, input logic [31:0] eh, input logic [31:0] el,
                       input int inj);
        int lat, pulses, bsy;
        lat = 0; pulses = 0; bsy = 0;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (c == inj) begin
                op = 3'b010; srca = 32'h64; srcb = 32'h3;
            end else begin
                srca = $urandom; srcb = $urandom;
            end
            if (done) begin
                pulses++;
                if (lat == 0) lat = c;
            end
            if (busy) bsy++;
            if (lat != 0 && c >= lat + 2) break;
        end
        start = 1'b0;
        chk({tag, ".lat"},    64'(lat),    64'(exp_lat));
        chk({tag, ".pulses"}, 64'(pulses), (exp_lat != 0) ? 64'd1 : 64'd0);
        chk({tag, ".busy"},   64'(bsy),    64'(exp_busy));
        chk({tag, ".hi"},     64'(hi),     64'(eh));
        chk({tag, ".lo"},     64'(lo),     64'(el));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi",   64'(hi),   64'd0);
        chk("rst.lo",   64'(lo),   64'd0);
        reset = 1'b1;

        run("mult_neg3x5",   3'b000, 32'hFFFFFFFD, 32'd5,        34, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run("multu_max",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, 32'hFFFFFFFE, 32'h00000001, 0);
        run("mtlo",          3'b101, 32'h00001234, 32'h0,         1,  0, 32'hFFFFFFFE, 32'h00001234, 0);
        run("mthi",          3'b100, 32'h0000ABCD, 32'h0,         1,  0, 32'h0000ABCD, 32'h00001234, 0);
        run("reserved",      3'b110, 32'h55555555, 32'h1,         0,  0, 32'h0000ABCD, 32'h00001234, 0);
        run("div_neg7by2",   3'b010, 32'hFFFFFFF9, 32'd2,        34, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run("divu_7by2",     3'b011, 32'd7,        32'd2,        34, 33, 32'h00000001, 32'h00000003, 0);
        run("div_7byneg2",   3'b010, 32'd7,        32'hFFFFFFFE, 34, 33, 32'h00000001, 32'hFFFFFFFD, 0);
        run("div_ovf",       3'b010, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h00000000, 32'h80000000, 0);
        run("divu_by0",      3'b011, 32'h0000DEAD, 32'h0,        EO_LAT, EO_LAT-1, 32'h0000DEAD, 32'hFFFFFFFF, 0);
        run("div_neg_by0",   3'b010, 32'hFFFFFFF9, 32'h0,        EO_LAT, EO_LAT-1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        run("mult_zero",     3'b000, 32'h0,        32'd5,        EO_LAT, EO_LAT-1, 32'h00000000, 32'h00000000, 0);
        run("mult_busy_ign", 3'b000, 32'd7,        32'hFFFFFFFE, 34, 33, 32'hFFFFFFFF, 32'hFFFFFFF2, 5);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'b011; srca = 32'd100; srcb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst.busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.hi",   64'(hi),   64'd0);
        chk("arst.lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset = 1'b1;

        run("multu_6x7", 3'b001, 32'd6, 32'd7, 34, 33, 32'h00000000, 32'd42, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
